// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
// Optional statistics counters are enabled with DCACHE_STATS_EN.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  localparam int LINE_BITS = 128;

  function automatic int offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int line_bytes, input int num_sets);
    return 32 - offset_w(line_bytes) - index_w(num_sets);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid, dirty and line storage for the data cache.
// Asynchronous read by index, synchronous word/line writes.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BITS / 8,
  parameter int NUM_SETS   = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [index_w(NUM_SETS)-1:0]             i_idx,
  output logic [tag_w(LINE_BYTES, NUM_SETS)-1:0]   o_tag,
  output logic                                     o_valid,
  output logic                                     o_dirty,
  output logic [LINE_BYTES*8-1:0]                  o_line,
  input  logic                                     i_wr_word,
  input  logic [offset_w(LINE_BYTES)-3:0]          i_sel,
  input  logic [31:0]                              i_wdata,
  input  logic                                     i_wr_line,
  input  logic [tag_w(LINE_BYTES, NUM_SETS)-1:0]   i_tag,
  input  logic [LINE_BYTES*8-1:0]                  i_line,
  input  logic                                     i_clr_dirty
);

  localparam int TW = tag_w(LINE_BYTES, NUM_SETS);
  localparam int LB = LINE_BYTES * 8;

  logic [TW-1:0]       r_tag  [NUM_SETS];
  logic [LB-1:0]       r_data [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;

  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_line  = r_data[i_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_wr_line) begin
        r_valid[i_idx] <= 1'b1;
        r_dirty[i_idx] <= 1'b0;
      end
      if (i_clr_dirty) r_dirty[i_idx] <= 1'b0;
      if (i_wr_word)   r_dirty[i_idx] <= 1'b1;
    end
  end

  // Contents survive reset; only the valid bits matter afterwards.
  always_ff @(posedge clk) begin
    if (i_wr_line) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_line;
    end
    if (i_wr_word) r_data[i_idx][32*int'(i_sel) +: 32] <= i_wdata;
  end

endmodule

// File: rtl/dcache_unit.sv
// Direct-mapped write-back/write-allocate data cache with miss FSM.
// Define DCACHE_STATS_EN to enable the hit/miss statistics counters.
module dcache_unit
  import dcache_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BITS / 8,
  parameter int NUM_SETS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req_valid,
  output logic                    cpu_ready,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic                    cpu_resp_valid,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic                    mem_ready,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int OW = offset_w(LINE_BYTES);
  localparam int IW = index_w(NUM_SETS);
  localparam int TW = tag_w(LINE_BYTES, NUM_SETS);
  localparam int SW = OW - 2;
  localparam int LB = LINE_BYTES * 8;

  state_t      r_state;
  logic        r_we;
  logic        r_missed;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [TW-1:0] w_tag_q;
  logic [SW-1:0] w_sel;
  logic          w_valid;
  logic          w_dirty;
  logic [LB-1:0] w_line;
  logic [31:0]   w_word;
  logic          w_cmp;
  logic          w_hit;
  logic          w_resp;
  logic          w_wb;
  logic          w_alloc;

  assign w_idx   = r_addr[OW +: IW];
  assign w_tag   = r_addr[31 -: TW];
  assign w_sel   = r_addr[2 +: SW];
  assign w_word  = w_line[32*int'(w_sel) +: 32];
  assign w_cmp   = (r_state == COMPARE);
  assign w_wb    = (r_state == WRITEBACK);
  assign w_alloc = (r_state == ALLOCATE);
  assign w_hit   = w_valid && (w_tag_q == w_tag);
  assign w_resp  = w_cmp && w_hit;

  dcache_array #(
    .LINE_BYTES(LINE_BYTES),
    .NUM_SETS  (NUM_SETS)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .i_idx      (w_idx),
    .o_tag      (w_tag_q),
    .o_valid    (w_valid),
    .o_dirty    (w_dirty),
    .o_line     (w_line),
    .i_wr_word  (w_resp && r_we),
    .i_sel      (w_sel),
    .i_wdata    (r_wdata),
    .i_wr_line  (w_alloc && mem_ready),
    .i_tag      (w_tag),
    .i_line     (mem_rdata),
    .i_clr_dirty(w_wb && mem_ready)
  );

  // Outputs decode from the state register and latched request only.
  assign cpu_ready      = (r_state == IDLE);
  assign cpu_resp_valid = w_resp;
  assign cpu_rdata      = (w_resp && !r_we) ? w_word : 32'd0;
  assign cpu_hit        = w_resp && !r_missed;
  assign mem_req        = w_wb || w_alloc;
  assign mem_we         = w_wb;
  assign mem_wdata      = w_wb ? w_line : '0;

  always_comb begin
    mem_addr = 32'd0;
    if (w_wb)    mem_addr = {w_tag_q, w_idx, {OW{1'b0}}};
    if (w_alloc) mem_addr = {w_tag, w_idx, {OW{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_missed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cpu_req_valid) begin
            r_we     <= cpu_we;
            r_addr   <= cpu_addr[31:2];
            r_wdata  <= cpu_wdata;
            r_missed <= 1'b0;
            r_state  <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            r_state <= IDLE;
          end else begin
            r_missed <= 1'b1;
            r_state  <= (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (mem_ready) r_state <= ALLOCATE;
        ALLOCATE:  if (mem_ready) r_state <= COMPARE;
        default:   r_state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  // Only the first lookup of a request is classified.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (w_cmp && !r_missed) begin
      if (w_hit) r_hits   <= r_hits + 32'd1;
      else       r_misses <= r_misses + 32'd1;
    end
  end

  assign hit_count  = r_hits;
  assign miss_count = r_misses;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
